// File: rtl/gsm_wr_sched.sv
// gsm_wr_sched: round-robin ingress write scheduler with fresh/recycled cell address allocation
module gsm_wr_sched #(
  parameter int NIN    = 4,
  parameter int MWIDTH = 4,
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 9
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NIN-1:0]        i_req,
  input  logic [NIN*DWIDTH-1:0] i_data,
  input  logic [NIN*MWIDTH-1:0] i_multicast,
  output logic [NIN-1:0]        o_gnt,
  output logic                  o_drop,
  output logic                  o_wr_en,
  output logic [AWIDTH-1:0]     o_wr_addr,
  output logic [DWIDTH-1:0]     o_wr_data,
  output logic [MWIDTH-1:0]     o_multicast,
  input  logic                  i_buf_free,
  input  logic [AWIDTH-1:0]     i_buf_free_addr,
  output logic [AWIDTH:0]       o_free_cnt,
  output logic                  o_err
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int RW = NIN > 1 ? $clog2(NIN) : 1;
  typedef enum logic {FRESH, RECYCLE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rr_q, rr_d, win_idx;
  logic [AWIDTH-1:0] fresh_q, fresh_d, alloc_addr, wr_addr_q, wr_addr_d;
  logic [AWIDTH:0] head_q, head_d, tail_q, tail_d, free_cnt_q, free_cnt_d;
  logic [AWIDTH-1:0] fifo_mem [DEPTH];
  logic [DWIDTH-1:0] wr_data_q, wr_data_d, data_sel;
  logic [MWIDTH-1:0] mc_q, mc_d, mc_sel;
  logic wr_en_q, wr_en_d, drop_q, drop_d, err_q, err_d;
  logic found, mc_zero, avail, grant, alloc, pop, push, overflow;
  always_comb begin
    found = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NIN; i++)
      if (!found && i_req[(int'(rr_q) + i) % NIN]) begin
        found = 1'b1;
        win_idx = RW'((int'(rr_q) + i) % NIN);
      end
  end
  assign mc_sel = i_multicast[int'(win_idx)*MWIDTH +: MWIDTH];
  assign data_sel = i_data[int'(win_idx)*DWIDTH +: DWIDTH];
  assign mc_zero = mc_sel == '0;
  // Zero-multicast cells are granted and discarded even when no address is free
  assign avail = state_q == FRESH || head_q != tail_q;
  assign grant = found && !clr && (mc_zero || avail);
  assign alloc = grant && !mc_zero;
  assign pop = alloc && state_q == RECYCLE;
  assign overflow = i_buf_free && free_cnt_q == (AWIDTH+1)'(DEPTH);
  assign push = i_buf_free && !overflow;
  assign alloc_addr = state_q == FRESH ? fresh_q : fifo_mem[head_q[AWIDTH-1:0]];
  assign o_gnt = grant ? NIN'(1) << win_idx : '0;
  always_comb begin
    rr_d = grant ? (win_idx == RW'(NIN-1) ? '0 : win_idx + 1'b1) : rr_q;
    fresh_d = alloc && state_q == FRESH ? fresh_q + 1'b1 : fresh_q;
    state_d = alloc && state_q == FRESH && fresh_q == '1 ? RECYCLE : state_q;
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    free_cnt_d = free_cnt_q + (AWIDTH+1)'(push) - (AWIDTH+1)'(alloc);
    wr_en_d = alloc;
    wr_addr_d = alloc ? alloc_addr : '0;
    wr_data_d = alloc ? data_sel : '0;
    mc_d = alloc ? mc_sel : '0;
    drop_d = grant && mc_zero;
    err_d = err_q || overflow;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= FRESH;
      rr_q <= '0;
      fresh_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      free_cnt_q <= (AWIDTH+1)'(DEPTH);
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      mc_q <= '0;
      drop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      fresh_q <= fresh_d;
      head_q <= head_d;
      tail_q <= tail_d;
      free_cnt_q <= free_cnt_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      mc_q <= mc_d;
      drop_q <= drop_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk)
    if (push && !clr) fifo_mem[tail_q[AWIDTH-1:0]] <= i_buf_free_addr;
  assign o_wr_en = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_multicast = mc_q;
  assign o_drop = drop_q;
  assign o_err = err_q;
  assign o_free_cnt = free_cnt_q;
endmodule

// File: tb/tb_gsm_wr_sched.sv
// tb_gsm_wr_sched: directed checks of grant order, allocation, recycling, drops and overflow
module tb_gsm_wr_sched;
  logic clk = 1'b0, clr = 1'b1;
  logic [3:0] i_req = '0;
  logic [511:0] i_data = '0;
  logic [15:0] i_multicast = '0;
  logic [3:0] o_gnt;
  logic o_drop, o_wr_en, o_err, i_buf_free = 1'b0;
  logic [8:0] o_wr_addr, i_buf_free_addr = '0;
  logic [127:0] o_wr_data;
  logic [3:0] o_multicast;
  logic [9:0] o_free_cnt;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  gsm_wr_sched dut (
    .clk(clk), .clr(clr), .i_req(i_req), .i_data(i_data), .i_multicast(i_multicast),
    .o_gnt(o_gnt), .o_drop(o_drop), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_multicast(o_multicast), .i_buf_free(i_buf_free),
    .i_buf_free_addr(i_buf_free_addr), .o_free_cnt(o_free_cnt), .o_err(o_err)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_wr_en", 128'(o_wr_en), 128'(0));
    chk("rst_wr_addr", 128'(o_wr_addr), 128'(0));
    chk("rst_free_cnt", 128'(o_free_cnt), 128'(512));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_drop", 128'(o_drop), 128'(0));
    // single request from port 2
    i_req = 4'b0100;
    i_multicast[8 +: 4] = 4'b0101;
    i_data[256 +: 128] = {16{8'hA5}};
    #1 chk("p2_gnt", 128'(o_gnt), 128'(4'b0100));
    @(negedge clk);
    i_req = '0;
    chk("p2_wr_en", 128'(o_wr_en), 128'(1));
    chk("p2_wr_addr", 128'(o_wr_addr), 128'(0));
    chk("p2_mc", 128'(o_multicast), 128'(4'b0101));
    chk("p2_data", o_wr_data, {16{8'hA5}});
    chk("p2_free_cnt", 128'(o_free_cnt), 128'(511));
    @(negedge clk);
    chk("p2_wr_pulse", 128'(o_wr_en), 128'(0));
    // all four ports request: round-robin from port 0
    do_clr();
    for (int k = 0; k < 4; k++) begin
      i_multicast[k*4 +: 4] = 4'b0001;
      i_data[k*128 +: 128] = 128'(k + 1);
    end
    i_req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_gnt", 128'(o_gnt), 128'(4'b0001 << (i % 4)));
      @(negedge clk);
      chk("rr_wr_addr", 128'(o_wr_addr), 128'(i));
      chk("rr_wr_data", o_wr_data, 128'(i % 4 + 1));
    end
    i_req = '0;
    chk("rr_free_cnt", 128'(o_free_cnt), 128'(506));
    // exhaust all fresh addresses from port 0
    do_clr();
    i_req = 4'b0001;
    repeat (512) @(negedge clk);
    chk("exh_last_addr", 128'(o_wr_addr), 128'(511));
    #1 chk("exh_no_gnt", 128'(o_gnt), 128'(0));
    chk("exh_free_cnt", 128'(o_free_cnt), 128'(0));
    @(negedge clk);
    chk("exh_no_wr", 128'(o_wr_en), 128'(0));
    // free 37 while still requesting: no bypass
    i_buf_free = 1'b1;
    i_buf_free_addr = 9'd37;
    #1 chk("f37_no_bypass", 128'(o_gnt), 128'(0));
    @(negedge clk);
    i_buf_free = 1'b0;
    chk("f37_free_cnt", 128'(o_free_cnt), 128'(1));
    #1 chk("f37_gnt", 128'(o_gnt), 128'(4'b0001));
    @(negedge clk);
    chk("f37_wr_en", 128'(o_wr_en), 128'(1));
    chk("f37_wr_addr", 128'(o_wr_addr), 128'(37));
    chk("f37_free_cnt0", 128'(o_free_cnt), 128'(0));
    // free 9 in the same cycle as a request on an empty FIFO
    i_buf_free = 1'b1;
    i_buf_free_addr = 9'd9;
    #1 chk("f9_stall", 128'(o_gnt), 128'(0));
    @(negedge clk);
    i_buf_free = 1'b0;
    #1 chk("f9_gnt", 128'(o_gnt), 128'(4'b0001));
    @(negedge clk);
    i_req = '0;
    chk("f9_wr_addr", 128'(o_wr_addr), 128'(9));
    // zero multicast from port 1 while exhausted
    i_req = 4'b0010;
    i_multicast[4 +: 4] = 4'b0000;
    #1 chk("drop_gnt", 128'(o_gnt), 128'(4'b0010));
    @(negedge clk);
    i_req = '0;
    chk("drop_pulse", 128'(o_drop), 128'(1));
    chk("drop_no_wr", 128'(o_wr_en), 128'(0));
    chk("drop_free_cnt", 128'(o_free_cnt), 128'(0));
    // push 5 and 6, then pop old head while pushing 7
    i_buf_free = 1'b1;
    i_buf_free_addr = 9'd5;
    @(negedge clk);
    chk("drop_one_cycle", 128'(o_drop), 128'(0));
    i_buf_free_addr = 9'd6;
    @(negedge clk);
    i_buf_free_addr = 9'd7;
    i_req = 4'b0001;
    #1 chk("pp_gnt", 128'(o_gnt), 128'(4'b0001));
    @(negedge clk);
    i_req = '0;
    i_buf_free = 1'b0;
    chk("pp_wr_addr", 128'(o_wr_addr), 128'(5));
    chk("pp_free_cnt", 128'(o_free_cnt), 128'(2));
    // overflow with a full free list
    do_clr();
    i_buf_free = 1'b1;
    i_buf_free_addr = 9'd3;
    @(negedge clk);
    i_buf_free = 1'b0;
    chk("ovf_err", 128'(o_err), 128'(1));
    chk("ovf_free_cnt", 128'(o_free_cnt), 128'(512));
    @(negedge clk);
    chk("ovf_sticky", 128'(o_err), 128'(1));
    // clr mid-stream with a write in flight
    i_req = 4'b0001;
    @(negedge clk);
    chk("mid_wr_en", 128'(o_wr_en), 128'(1));
    clr = 1'b1;
    i_buf_free = 1'b1;
    #1 chk("mid_clr_no_gnt", 128'(o_gnt), 128'(0));
    @(negedge clk);
    clr = 1'b0;
    i_req = '0;
    i_buf_free = 1'b0;
    chk("mid_wr_en_clr", 128'(o_wr_en), 128'(0));
    chk("mid_wr_addr", 128'(o_wr_addr), 128'(0));
    chk("mid_wr_data", o_wr_data, 128'(0));
    chk("mid_mc", 128'(o_multicast), 128'(0));
    chk("mid_err", 128'(o_err), 128'(0));
    chk("mid_free_cnt", 128'(o_free_cnt), 128'(512));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
